sram_pingpong_writer: RTL and testbench

//   Streams 32-bit LVDS capture words into port 2 of the dual-port on-chip SRAM as a

---
 rtl/sram_pingpong_writer.sv | 206 ++++++++++++++++++++
 tb/tb_sram_pingpong_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pingpong_writer.sv
// ----------------------------------------------------------------------------
// sram_pingpong_writer
//
// Streams capture words from the LVDS deserialiser into port 2 of the
// dual-port on-chip SRAM. The SRAM is used as a ping-pong buffer. The lower
// half is filled first, then the upper half, and the writer keeps alternating.
// When a half is completely written, its buf_full bit is raised and irq tells
// the HPS. The HPS drains that half through port 1 and then frees it with a
// one-cycle buf_ack pulse. The writer never writes into a half that is still
// flagged full. If it catches up with the HPS it stalls in WAIT, and any beat
// offered during the stall is recorded in the sticky overflow flag.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   enable          capture enable (level); dropping it abandons the
//                   partial half and restarts at address 0
//   snk_data        capture word
//   snk_valid       snk_data valid
//   snk_ready       beat accepted when snk_valid & snk_ready
//   sram_address    {half, offset} word address of the current write
//   sram_chipselect write strobe (same as sram_write)
//   sram_write      write strobe, one clock after the beat is accepted
//   sram_byteenable all ones while writing, zero otherwise
//   sram_writedata  registered capture word
//   buf_ack         per-half release pulse from the HPS
//   buf_full        per-half "complete, awaiting ack" flags
//   irq             OR of buf_full
//   overflow        sticky: a beat was offered while stalled in WAIT
//   overflow_clr    clears overflow (a new overflow in the same cycle wins)
// ----------------------------------------------------------------------------
module sram_pingpong_writer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     sram_address,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic [DATA_W-1:0]     sram_writedata,
    input  logic [1:0]            buf_ack,
    output logic [1:0]            buf_full,
    output logic                  irq,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int OFF_W = ADDR_W - 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [OFF_W-1:0] LAST_OFF = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               half_q, half_d;
    logic [OFF_W-1:0]   offset_q, offset_d;

    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [1:0]         buf_full_q, buf_full_d;
    logic               overflow_q, overflow_d;

    logic               accept;
    logic               last_beat;
    logic               wait_drop;
    logic [1:0]         buf_busy;
    logic [1:0]         set_mask;

    // A half counts as busy only if it is flagged and is not being released
    // in this very cycle. Using this value lets the writer go straight back
    // to FILL on the edge that carries the ack, with no extra cycle.
    assign buf_busy = buf_full_q & ~buf_ack;

    // State register: FSM state plus the write pointer (half, offset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            half_q   <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            offset_q <= offset_d;
        end
    end

    // Next-state logic. The write pointer advances together with the state
    // so that crossing a half boundary costs no dead cycle. Whenever enable
    // drops, the pointer returns to the start of the lower half.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        offset_d = offset_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    half_d   = 1'b0;
                    offset_d = '0;
                    state_d  = buf_busy[0] ? ST_WAIT : ST_FILL;
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    half_d   = 1'b0;
                    offset_d = '0;
                end else if (accept) begin
                    if (offset_q == LAST_OFF) begin
                        half_d   = ~half_q;
                        offset_d = '0;
                        state_d  = buf_busy[~half_q] ? ST_WAIT : ST_FILL;
                    end else begin
                        offset_d = offset_q + OFF_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    half_d   = 1'b0;
                    offset_d = '0;
                end else if (!buf_busy[half_q]) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                half_d   = 1'b0;
                offset_d = '0;
            end
        endcase
    end

    // FSM outputs. Beats are accepted only while filling. A valid beat seen
    // while stalled is dropped upstream, so it is recorded as an overflow.
    always_comb begin
        snk_ready = (state_q == ST_FILL) && enable;
        accept    = snk_valid && snk_ready;
        last_beat = accept && (offset_q == LAST_OFF);
        wait_drop = (state_q == ST_WAIT) && snk_valid;
    end

    // Datapath next values. The write port is fully registered, so each beat
    // appears on the SRAM one clock after it is accepted. The full flag of a
    // half is set on the same edge that drives its last write strobe. A set
    // takes priority over an ack of the same bit.
    always_comb begin
        wr_d     = accept;
        addr_d   = addr_q;
        data_d   = data_q;
        set_mask = 2'b00;
        if (accept) begin
            addr_d = {half_q, offset_q};
            data_d = snk_data;
        end
        if (last_beat) begin
            set_mask[half_q] = 1'b1;
        end
        buf_full_d = buf_busy | set_mask;
        if (wait_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            buf_full_q <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            buf_full_q <= buf_full_d;
            overflow_q <= overflow_d;
        end
    end

    assign sram_write      = wr_q;
    assign sram_chipselect = wr_q;
    assign sram_byteenable = {BE_W{wr_q}};
    assign sram_address    = addr_q;
    assign sram_writedata  = data_q;
    assign buf_full        = buf_full_q;
    assign irq             = |buf_full_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_sram_pingpong_writer.sv
// ----------------------------------------------------------------------------
// tb_sram_pingpong_writer
//
// Directed, table-driven bench for sram_pingpong_writer with ADDR_W=4, which
// gives 8-word halves. Each vector holds the inputs for one clock and the
// outputs expected from them. snk_ready is expected before the edge, and the
// registered SRAM and flag outputs are expected just after the edge. A few
// hand-written sequences cover asynchronous reset mid-fill and the
// set-versus-ack priority of buf_full.
// ----------------------------------------------------------------------------
module tb_sram_pingpong_writer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic                clk;
    logic                reset;
    logic                enable;
    logic [DATA_W-1:0]   snk_data;
    logic                snk_valid;
    logic                snk_ready;
    logic [ADDR_W-1:0]   sram_address;
    logic                sram_chipselect;
    logic                sram_write;
    logic [DATA_W/8-1:0] sram_byteenable;
    logic [DATA_W-1:0]   sram_writedata;
    logic [1:0]          buf_ack;
    logic [1:0]          buf_full;
    logic                irq;
    logic                overflow;
    logic                overflow_clr;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] data;
        logic [1:0]  ack;
        logic        clr;
        logic        expRdy;
        logic        expWr;
        logic [3:0]  expAddr;
        logic [31:0] expData;
        logic [1:0]  expFull;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    sram_pingpong_writer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready),
        .sram_address    (sram_address),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_byteenable (sram_byteenable),
        .sram_writedata  (sram_writedata),
        .buf_ack         (buf_ack),
        .buf_full        (buf_full),
        .irq             (irq),
        .overflow        (overflow),
        .overflow_clr    (overflow_clr)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic en, input logic vld,
                                   input logic [31:0] data, input logic [1:0] ack,
                                   input logic clr, input logic expRdy,
                                   input logic expWr, input logic [3:0] expAddr,
                                   input logic [31:0] expData,
                                   input logic [1:0] expFull, input logic expOvf);
        vec_t v;
        v.en      = en;
        v.vld     = vld;
        v.data    = data;
        v.ack     = ack;
        v.clr     = clr;
        v.expRdy  = expRdy;
        v.expWr   = expWr;
        v.expAddr = expAddr;
        v.expData = expData;
        v.expFull = expFull;
        v.expOvf  = expOvf;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one vector for one clock. This task is entered just after a
    // rising edge, and it returns just after the next rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        enable       = v.en;
        snk_valid    = v.vld;
        snk_data     = v.data;
        buf_ack      = v.ack;
        overflow_clr = v.clr;
        #2;
        checkOutput({tag, " snk_ready"}, 32'(snk_ready), 32'(v.expRdy));
        @(posedge clk);
        #1;
        checkOutput({tag, " sram_write"}, 32'(sram_write), 32'(v.expWr));
        checkOutput({tag, " sram_chipselect"}, 32'(sram_chipselect), 32'(v.expWr));
        checkOutput({tag, " sram_byteenable"}, 32'(sram_byteenable),
                    v.expWr ? 32'hF : 32'h0);
        if (v.expWr) begin
            checkOutput({tag, " sram_address"}, 32'(sram_address), 32'(v.expAddr));
            checkOutput({tag, " sram_writedata"}, sram_writedata, v.expData);
        end
        checkOutput({tag, " buf_full"}, 32'(buf_full), 32'(v.expFull));
        checkOutput({tag, " irq"}, 32'(irq), 32'(|v.expFull));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(v.expOvf));
    endtask

    task automatic stepVec(input logic en, input logic vld, input logic [31:0] data,
                           input logic [1:0] ack, input logic clr, input logic expRdy,
                           input logic expWr, input logic [3:0] expAddr,
                           input logic [31:0] expData, input logic [1:0] expFull,
                           input logic expOvf, input string tag);
        vec_t v;
        v.en      = en;
        v.vld     = vld;
        v.data    = data;
        v.ack     = ack;
        v.clr     = clr;
        v.expRdy  = expRdy;
        v.expWr   = expWr;
        v.expAddr = expAddr;
        v.expData = expData;
        v.expFull = expFull;
        v.expOvf  = expOvf;
        applyStimulus(v, tag);
    endtask

    initial begin
        // Vector table. Arguments are the inputs (en, vld, data, ack, clr),
        // followed by the expected outputs (rdy, wr, addr, data, full, ovf).
        addVec(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 8; i++)
            addVec(1, 1, 32'h100 + i, 2'b00, 0, 1, 1, 4'(i), 32'h100 + i,
                   (i == 7) ? 2'b01 : 2'b00, 0);
        for (int i = 0; i < 8; i++)
            addVec(1, 1, 32'h108 + i, 2'b00, 0, 1, 1, 4'(8 + i), 32'h108 + i,
                   (i == 7) ? 2'b11 : 2'b01, 0);
        addVec(1, 1, 32'h200, 2'b00, 0, 0, 0, 0, 0, 2'b11, 1);
        addVec(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b10, 1);
        addVec(1, 1, 32'h200, 2'b00, 1, 1, 1, 0, 32'h200, 2'b10, 0);
        for (int i = 1; i < 7; i++)
            addVec(1, 1, 32'h200 + i, 2'b00, 0, 1, 1, 4'(i), 32'h200 + i, 2'b10, 0);
        addVec(1, 1, 32'h207, 2'b10, 0, 1, 1, 7, 32'h207, 2'b01, 0);
        addVec(1, 1, 32'h208, 2'b00, 0, 1, 1, 8, 32'h208, 2'b01, 0);
        addVec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0);
        addVec(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0);
        addVec(1, 1, 32'hDEAD, 2'b00, 1, 0, 0, 0, 0, 2'b01, 1);
        addVec(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1);
        addVec(1, 1, 32'h300, 2'b00, 1, 1, 1, 0, 32'h300, 2'b00, 0);
        for (int i = 1; i < 5; i++)
            addVec(1, 1, 32'h300 + i, 2'b00, 0, 1, 1, 4'(i), 32'h300 + i, 2'b00, 0);
        addVec(0, 1, 32'h399, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        addVec(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        addVec(1, 1, 32'h400, 2'b00, 0, 1, 1, 0, 32'h400, 2'b00, 0);

        reset        = 1'b1;
        enable       = 1'b0;
        snk_valid    = 1'b0;
        snk_data     = '0;
        buf_ack      = 2'b00;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] checking reset state");
        checkOutput("reset snk_ready", 32'(snk_ready), 0);
        checkOutput("reset sram_write", 32'(sram_write), 0);
        checkOutput("reset sram_address", 32'(sram_address), 0);
        checkOutput("reset buf_full", 32'(buf_full), 0);
        checkOutput("reset irq", 32'(irq), 0);
        checkOutput("reset overflow", 32'(overflow), 0);

        $display("[TB] running %0d table vectors", vecs.size());
        foreach (vecs[i])
            applyStimulus(vecs[i], $sformatf("v%0d", i));

        // An ack of buf_full[0] that arrives while bit 0 is being set must
        // leave the bit set.
        $display("[TB] set-versus-ack sequence");
        for (int i = 1; i < 7; i++)
            stepVec(1, 1, 32'h400 + i, 2'b00, 0, 1, 1, 4'(i), 32'h400 + i, 2'b00, 0,
                    $sformatf("sw%0d", i));
        stepVec(1, 1, 32'h407, 2'b01, 0, 1, 1, 7, 32'h407, 2'b01, 0, "sw_last");
        for (int i = 0; i < 3; i++)
            stepVec(1, 1, 32'h408 + i, 2'b00, 0, 1, 1, 4'(8 + i), 32'h408 + i,
                    2'b01, 0, $sformatf("sw_up%0d", i));

        // Assert the asynchronous reset while filling at offset 3 of the
        // upper half. The outputs must clear at once, without a clock edge.
        $display("[TB] reset mid-fill sequence");
        enable    = 1'b1;
        snk_valid = 1'b1;
        snk_data  = 32'hBAD;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst snk_ready", 32'(snk_ready), 0);
        checkOutput("rst sram_write", 32'(sram_write), 0);
        checkOutput("rst sram_chipselect", 32'(sram_chipselect), 0);
        checkOutput("rst sram_byteenable", 32'(sram_byteenable), 0);
        checkOutput("rst sram_address", 32'(sram_address), 0);
        checkOutput("rst sram_writedata", sram_writedata, 0);
        checkOutput("rst buf_full", 32'(buf_full), 0);
        checkOutput("rst irq", 32'(irq), 0);
        checkOutput("rst overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        snk_valid = 1'b0;
        stepVec(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, "rst_idle");
        stepVec(1, 1, 32'h500, 2'b00, 0, 1, 1, 0, 32'h500, 2'b00, 0, "rst_first");
        stepVec(1, 1, 32'h501, 2'b00, 0, 1, 1, 1, 32'h501, 2'b00, 0, "rst_second");

        enable    = 1'b0;
        snk_valid = 1'b0;
        buf_ack   = 2'b00;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
